// File: rtl/rrp_otf_convert_if.sv
// rtl/rrp_otf_convert_if.sv - signed-digit word in / two's-complement word out handshake bundle
interface rrp_otf_convert_if #(
    parameter int RADIX = 4,
    parameter int WIDTH = 16
);
    localparam int B     = $clog2(RADIX);
    localparam int D     = B + 1;
    localparam int OUT_W = B * (WIDTH + 1) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [(WIDTH+1)*D-1:0]   s_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_data;
    logic                     out_err;

    modport master (
        output in_valid, s_in, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, s_in, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rrp_otf_convert.sv
// rtl/rrp_otf_convert.sv - MSD-first on-the-fly signed-digit to two's-complement converter
module rrp_otf_convert #(
    parameter int RADIX = 4,
    parameter int WIDTH = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    rrp_otf_convert_if.slave    bus
);
    localparam int B     = $clog2(RADIX);
    localparam int D     = B + 1;
    localparam int OUT_W = B * (WIDTH + 1) + 1;
    localparam int IN_W  = (WIDTH + 1) * D;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state;
    logic [IN_W-1:0]     sreg;
    logic [D-1:0]        dig_r;
    logic                dig_v;
    logic [OUT_W-1:0]    q_r;
    logic [OUT_W-1:0]    qm_r;
    logic [CW-1:0]       cnt;
    logic                err_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [OUT_W-1:0]    out_data_r;
    logic                out_err_r;

    logic [B-1:0]        dig_m1;
    logic [OUT_W-1:0]    q_base;
    logic [OUT_W-1:0]    qm_base;
    logic [OUT_W-1:0]    q_nxt;
    logic [OUT_W-1:0]    qm_nxt;
    logic                dig_bad;
    logic                err_nxt;

    // Digit terms RADIX+q and RADIX-1+q reduce to q and q-1 modulo RADIX,
    // so only the low B bits of the digit (and of digit-1) are appended.
    always_comb begin
        dig_m1  = dig_r[B-1:0] - B'(1);
        q_base  = dig_r[D-1] ? qm_r : q_r;
        qm_base = (!dig_r[D-1] && (dig_r != '0)) ? q_r : qm_r;
        q_nxt   = (q_base << B)  | OUT_W'(dig_r[B-1:0]);
        qm_nxt  = (qm_base << B) | OUT_W'(dig_m1);
        // A D-bit digit spans -RADIX..RADIX-1, so -RADIX is the only illegal code.
        dig_bad = (dig_r == {1'b1, {B{1'b0}}});
        err_nxt = err_r | dig_bad;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sreg        <= '0;
            dig_r       <= '0;
            dig_v       <= 1'b0;
            q_r         <= '0;
            qm_r        <= '1;
            cnt         <= CW'(WIDTH);
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg       <= bus.s_in;
                        q_r        <= '0;
                        qm_r       <= '1;
                        cnt        <= CW'(WIDTH);
                        err_r      <= 1'b0;
                        dig_v      <= 1'b0;
                        in_ready_r <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    // First CONV cycle only fills the digit register; each later
                    // cycle folds in one digit while the next one is fetched.
                    dig_r <= sreg[IN_W-1 -: D];
                    sreg  <= sreg << D;
                    dig_v <= 1'b1;
                    if (dig_v) begin
                        q_r   <= q_nxt;
                        qm_r  <= qm_nxt;
                        err_r <= err_nxt;
                        cnt   <= cnt - CW'(1);
                        if (cnt == '0) begin
                            out_data_r  <= q_nxt;
                            out_err_r   <= err_nxt;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_rrp_otf_convert.sv
// tb/tb_rrp_otf_convert.sv - directed and random checks of rrp_otf_convert at two configurations
module tb_rrp_otf_convert;
    logic clock;
    logic reset_n;

    int n_assert;
    int n_fail;

    rrp_otf_convert_if #(.RADIX(4), .WIDTH(4))  b4 ();
    rrp_otf_convert_if #(.RADIX(2), .WIDTH(16)) b2 ();

    rrp_otf_convert #(.RADIX(4), .WIDTH(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b4)
    );

    rrp_otf_convert #(.RADIX(2), .WIDTH(16)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] w4(input int a, input int b, input int c, input int d, input int e);
        return {3'(a), 3'(b), 3'(c), 3'(d), 3'(e)};
    endfunction

    task automatic run4(input logic [14:0] w, output logic [10:0] d, output logic e, output int lat);
        @(negedge clock);
        b4.in_valid = 1'b1;
        b4.s_in     = w;
        @(posedge clock);
        @(negedge clock);
        b4.in_valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("r4_out_valid_seen", 64'(b4.out_valid), 64'd1);
        d = b4.out_data;
        e = b4.out_err;
    endtask

    task automatic pop4();
        b4.out_ready = 1'b1;
        @(negedge clock);
        b4.out_ready = 1'b0;
    endtask

    task automatic run2(input logic [33:0] w, output logic [17:0] d, output logic e, output int lat);
        @(negedge clock);
        b2.in_valid = 1'b1;
        b2.s_in     = w;
        @(posedge clock);
        @(negedge clock);
        b2.in_valid = 1'b0;
        lat = 0;
        while (!b2.out_valid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        chk("r2_out_valid_seen", 64'(b2.out_valid), 64'd1);
        d = b2.out_data;
        e = b2.out_err;
    endtask

    task automatic pop2();
        b2.out_ready = 1'b1;
        @(negedge clock);
        b2.out_ready = 1'b0;
    endtask

    initial begin
        logic [10:0] d4;
        logic [17:0] d2;
        logic        e;
        int          lat;
        logic [33:0] rw;
        longint      sum;
        logic [63:0] sum_v;
        int          dg;

        n_assert     = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        b4.in_valid  = 1'b0;
        b4.s_in      = '0;
        b4.out_ready = 1'b0;
        b2.in_valid  = 1'b0;
        b2.s_in      = '0;
        b2.out_ready = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_in_ready",  64'(b4.in_ready),  64'd1);
        chk("rst_out_valid", 64'(b4.out_valid), 64'd0);
        chk("rst_out_data",  64'(b4.out_data),  64'd0);
        chk("rst_out_err",   64'(b4.out_err),   64'd0);
        chk("rst2_in_ready", 64'(b2.in_ready),  64'd1);
        chk("rst2_out_data", 64'(b2.out_data),  64'd0);
        reset_n = 1'b1;

        // 1,-3,0,2,-1 in radix 4 = 256-192+8-1 = 71
        run4(w4(1, -3, 0, 2, -1), d4, e, lat);
        chk("t1_data",     64'(d4),           64'h047);
        chk("t1_err",      64'(e),            64'd0);
        chk("t1_latency",  64'(lat),          64'd6);
        chk("t1_in_ready", 64'(b4.in_ready),  64'd0);
        pop4();
        chk("t1_pop_valid", 64'(b4.out_valid), 64'd0);
        chk("t1_pop_ready", 64'(b4.in_ready),  64'd1);
        chk("t1_pop_hold",  64'(b4.out_data),  64'h047);

        // -256 - 3*85 = -511
        run4(w4(-1, -3, -3, -3, -3), d4, e, lat);
        chk("t2_neg_data", 64'(d4), 64'h601);
        chk("t2_neg_err",  64'(e),  64'd0);
        pop4();
        run4(w4(0, 0, 0, 0, 0), d4, e, lat);
        chk("t2_zero_data", 64'(d4), 64'h000);
        pop4();
        // 3*256+3*64+3*16+3*4+3 = 1023
        run4(w4(3, 3, 3, 3, 3), d4, e, lat);
        chk("t2_max_data", 64'(d4), 64'h3ff);
        pop4();

        run2({2'b01, {16{2'b11}}}, d2, e, lat);
        chk("t3_data",    64'(d2),  64'd1);
        chk("t3_err",     64'(e),   64'd0);
        chk("t3_latency", 64'(lat), 64'd18);
        pop2();

        // backpressure: result held, busy inputs ignored
        run4(w4(1, -3, 0, 2, -1), d4, e, lat);
        for (int i = 0; i < 5; i++) begin
            b4.in_valid = 1'b1;
            b4.s_in     = w4(-1, -3, -3, -3, -3);
            @(negedge clock);
            chk("t4_hold_data",  64'(b4.out_data),  64'h047);
            chk("t4_hold_valid", 64'(b4.out_valid), 64'd1);
            chk("t4_hold_ready", 64'(b4.in_ready),  64'd0);
        end
        b4.in_valid = 1'b0;
        pop4();
        chk("t4_release_ready", 64'(b4.in_ready),  64'd1);
        chk("t4_release_valid", 64'(b4.out_valid), 64'd0);
        repeat (8) @(negedge clock);
        chk("t4_no_capture", 64'(b4.out_valid), 64'd0);

        // illegal digit codes
        run2({{13{2'b00}}, 2'b10, {3{2'b00}}}, d2, e, lat);
        chk("t5_err2", 64'(e), 64'd1);
        pop2();
        run2({2'b01, {16{2'b11}}}, d2, e, lat);
        chk("t5_clear_err2",  64'(e),  64'd0);
        chk("t5_clear_data2", 64'(d2), 64'd1);
        pop2();
        run4(w4(0, 0, -4, 0, 0), d4, e, lat);
        chk("t5_err4", 64'(e), 64'd1);
        pop4();
        run4(w4(0, 1, 2, -2, 1), d4, e, lat);
        chk("t5_clear_err4",  64'(e),  64'd0);
        chk("t5_clear_data4", 64'(d4), 64'd89);
        pop4();

        // async reset mid-conversion
        @(negedge clock);
        b4.in_valid = 1'b1;
        b4.s_in     = w4(-1, -3, -3, -3, -3);
        @(posedge clock);
        @(negedge clock);
        b4.in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(b4.out_valid), 64'd0);
        chk("t6_rst_ready", 64'(b4.in_ready),  64'd1);
        chk("t6_rst_data",  64'(b4.out_data),  64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("t6_no_result", 64'(b4.out_valid), 64'd0);
        run4(w4(1, -3, 0, 2, -1), d4, e, lat);
        chk("t6_after_data", 64'(d4), 64'h047);
        pop4();

        // random legal radix-2 words against an integer reference sum
        for (int n = 0; n < 1000; n++) begin
            sum = 0;
            for (int i = 0; i < 17; i++) begin
                dg = int'($urandom_range(2)) - 1;
                rw[i*2 +: 2] = 2'(dg);
                sum = sum + longint'(dg) * (longint'(1) << i);
            end
            run2(rw, d2, e, lat);
            sum_v = 64'(sum);
            chk("t3_rand_data", 64'(d2), 64'(sum_v[17:0]));
            chk("t3_rand_err",  64'(e),  64'd0);
            pop2();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
